// File: rtl/fetch_queue_unit_pkg.sv
// rtl/fetch_queue_unit_pkg.sv - shared constants and fetch state encodings
package fetch_queue_unit_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

  // IDLE: nothing outstanding, WAIT: request outstanding, DROP: outstanding request is stale
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_inst_queue.sv
// rtl/fetch_inst_queue.sv - circular instruction queue holding {instr, pc} pairs
module fetch_inst_queue
  import fetch_queue_unit_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_instr,
  input  logic [DATA_W-1:0]        push_pc,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DATA_W-1:0]        head_instr,
  output logic [DATA_W-1:0]        head_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [DATA_W-1:0] pc_mem    [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  cnt;

  // Pointers and occupancy; flush wins over push/pop, pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (en) begin
      if (flush) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
        cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Entry storage, written at tail on push; cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= ZERO_DATA[DATA_W-1:0];
        pc_mem[i]    <= ZERO_DATA[DATA_W-1:0];
      end
    end else if (en && push && !flush) begin
      instr_mem[tail] <= push_instr;
      pc_mem[tail]    <= push_pc;
    end
  end

  assign head_instr = instr_mem[head];
  assign head_pc    = pc_mem[head];
  assign count      = cnt;

endmodule

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - prefetching instruction fetcher with redirect and response squash
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int                DATA_W   = DATA_WIDTH,
  parameter int                IQ_DEPTH = 4,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  output logic                       out_mem_ce,
  output logic [DATA_W-1:0]          out_mem_pc,
  input  logic                       in_mem_ce,
  input  logic [DATA_W-1:0]          in_mem_instr,
  input  logic                       in_rs_idle,
  input  logic                       in_lsb_idle,
  input  logic                       in_rob_idle,
  input  logic                       in_redirect_ce,
  input  logic [DATA_W-1:0]          in_redirect_pc,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_instr,
  output logic [DATA_W-1:0]          out_pc,
  output logic                       out_store_ce,
  output logic [$clog2(IQ_DEPTH):0]  out_iq_count
);

  localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

  fetch_state_e      state, state_nxt;
  logic [DATA_W-1:0] pc, pc_nxt;
  logic              mem_ce_q, mem_ce_nxt;
  logic [DATA_W-1:0] mem_pc_q, mem_pc_nxt;

  logic [CNT_W-1:0]  iq_count;
  logic [CNT_W:0]    next_count;
  logic              enq;
  logic              deq;
  logic              can_issue;

  assign enq          = (state == FETCH_WAIT) && in_mem_ce;
  assign out_valid    = (iq_count != '0);
  assign out_store_ce = out_valid && in_rs_idle && in_lsb_idle && in_rob_idle
                        && !in_redirect_ce && rdy;
  assign deq          = out_store_ce;

  // Occupancy after this cycle; the outstanding request's slot is reserved by issuing only below depth
  assign next_count = {1'b0, iq_count} + (CNT_W+1)'(enq) - (CNT_W+1)'(deq);
  assign can_issue  = next_count < (CNT_W+1)'(IQ_DEPTH);

  fetch_inst_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (IQ_DEPTH)
  ) u_iq (
    .clk        (clk),
    .rst        (rst),
    .en         (rdy),
    .push       (enq && !in_redirect_ce),
    .push_instr (in_mem_instr),
    .push_pc    (mem_pc_q),
    .pop        (deq),
    .flush      (in_redirect_ce),
    .head_instr (out_instr),
    .head_pc    (out_pc),
    .count      (iq_count)
  );

  // Next-state and issue decision; redirect overrides everything and never issues
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    mem_ce_nxt = FALSE;
    mem_pc_nxt = mem_pc_q;
    if (in_redirect_ce) begin
      pc_nxt = in_redirect_pc;
      case (state)
        FETCH_WAIT: state_nxt = in_mem_ce ? FETCH_IDLE : FETCH_DROP;
        FETCH_DROP: state_nxt = in_mem_ce ? FETCH_IDLE : FETCH_DROP;
        default:    state_nxt = FETCH_IDLE;
      endcase
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (can_issue) begin
            mem_ce_nxt = TRUE;
            mem_pc_nxt = pc;
            pc_nxt     = pc + DATA_W'(PC_STEP);
            state_nxt  = FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (in_mem_ce) begin
            if (can_issue) begin
              mem_ce_nxt = TRUE;
              mem_pc_nxt = pc;
              pc_nxt     = pc + DATA_W'(PC_STEP);
              state_nxt  = FETCH_WAIT;
            end else begin
              state_nxt = FETCH_IDLE;
            end
          end
        end
        FETCH_DROP: begin
          if (in_mem_ce) state_nxt = FETCH_IDLE;
        end
        default: state_nxt = FETCH_IDLE;
      endcase
    end
  end

  // State, pc and request registers; everything holds while rdy is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH_IDLE;
      pc       <= RESET_PC;
      mem_ce_q <= FALSE;
      mem_pc_q <= ZERO_DATA[DATA_W-1:0];
    end else if (rdy) begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      mem_ce_q <= mem_ce_nxt;
      mem_pc_q <= mem_pc_nxt;
    end
  end

  assign out_mem_ce   = mem_ce_q;
  assign out_mem_pc   = mem_pc_q;
  assign out_iq_count = iq_count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - randomized self-checking bench for fetch_queue_unit
module tb_fetch_queue_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        out_mem_ce;
  logic [31:0] out_mem_pc;
  logic        in_mem_ce = 1'b0;
  logic [31:0] in_mem_instr = '0;
  logic        in_rs_idle = 1'b1, in_lsb_idle = 1'b1, in_rob_idle = 1'b1;
  logic        in_redirect_ce = 1'b0;
  logic [31:0] in_redirect_pc = '0;
  logic        out_valid;
  logic [31:0] out_instr, out_pc;
  logic        out_store_ce;
  logic [2:0]  out_iq_count;

  logic        w_in_ce = 1'b0;
  logic [31:0] w_in_instr = '0;
  logic        w_ce, w_valid, w_store;
  logic [31:0] w_pc, w_instr_o, w_pc_o;
  logic [2:0]  w_cnt;

  always #5 clk = ~clk;

  fetch_queue_unit #(.DATA_W(32), .IQ_DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .out_mem_ce(out_mem_ce), .out_mem_pc(out_mem_pc),
    .in_mem_ce(in_mem_ce), .in_mem_instr(in_mem_instr),
    .in_rs_idle(in_rs_idle), .in_lsb_idle(in_lsb_idle), .in_rob_idle(in_rob_idle),
    .in_redirect_ce(in_redirect_ce), .in_redirect_pc(in_redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_store_ce(out_store_ce), .out_iq_count(out_iq_count)
  );

  fetch_queue_unit #(.DATA_W(32), .IQ_DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_wrap (
    .clk(clk), .rst(rst), .rdy(1'b1),
    .out_mem_ce(w_ce), .out_mem_pc(w_pc),
    .in_mem_ce(w_in_ce), .in_mem_instr(w_in_instr),
    .in_rs_idle(1'b1), .in_lsb_idle(1'b1), .in_rob_idle(1'b1),
    .in_redirect_ce(1'b0), .in_redirect_pc(32'h0),
    .out_valid(w_valid), .out_instr(w_instr_o), .out_pc(w_pc_o),
    .out_store_ce(w_store), .out_iq_count(w_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // reference model: a plain queue of {pc, instr} plus the outstanding-request bookkeeping
  logic [63:0] m_q[$];
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_req_pc = 32'h0;
  bit          m_out = 0, m_stale = 0, m_ce = 0;
  logic [31:0] m_ce_pc = 32'h0;

  // memory environment
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_pc = 32'h0;
  int          lat_lo = 1, lat_hi = 1;
  bit          w_pend = 0;
  logic [31:0] w_req_pc = 32'h0;

  int          cycle = 0;
  logic [31:0] issue_pc[$];
  int          issue_cyc[$];
  logic [31:0] disp_pc[$];
  logic [31:0] w_pcs[$];

  task automatic step(input bit redir, input logic [31:0] rpc, input bit stray);
    bit          mem_resp, resp, exp_store, was_stale, pre_ce, w_pre_ce;
    logic [31:0] pre_pc, w_pre_pc, drv_instr;
    mem_resp       = mem_pend && (mem_cnt == 0);
    resp           = mem_resp || stray;
    drv_instr      = mem_resp ? instr_of(mem_pc) : $urandom();
    in_redirect_ce = redir;
    in_redirect_pc = rpc;
    in_mem_ce      = resp;
    in_mem_instr   = drv_instr;
    w_in_ce        = w_pend;
    w_in_instr     = instr_of(w_req_pc);
    #1;
    exp_store = (m_q.size() != 0) && in_rs_idle && in_lsb_idle && in_rob_idle && !redir && rdy;
    check("valid", {31'b0, out_valid}, {31'b0, m_q.size() != 0});
    check("store_ce", {31'b0, out_store_ce}, {31'b0, exp_store});
    check("iq_count", {29'b0, out_iq_count}, m_q.size());
    if (m_q.size() != 0) begin
      check("head_pc", out_pc, m_q[0][63:32]);
      check("head_instr", out_instr, m_q[0][31:0]);
    end
    check("mem_ce", {31'b0, out_mem_ce}, {31'b0, m_ce});
    if (m_ce) check("mem_pc", out_mem_pc, m_ce_pc);
    pre_ce   = out_mem_ce;
    pre_pc   = out_mem_pc;
    w_pre_ce = w_ce;
    w_pre_pc = w_pc;
    if (pre_ce && rdy) begin
      issue_pc.push_back(pre_pc);
      issue_cyc.push_back(cycle);
    end
    if (out_store_ce) disp_pc.push_back(out_pc);
    @(posedge clk);
    cycle++;
    if (rdy) begin
      if (redir) begin
        m_q.delete();
        m_pc = rpc;
        m_ce = 0;
        if (m_out && resp) begin
          m_out = 0;
          m_stale = 0;
        end else if (m_out) begin
          m_stale = 1;
        end
      end else begin
        was_stale = 0;
        if (exp_store) void'(m_q.pop_front());
        if (resp && m_out) begin
          if (m_stale) begin
            was_stale = 1;
            m_stale = 0;
          end else begin
            m_q.push_back({m_req_pc, drv_instr});
          end
          m_out = 0;
        end
        if (!m_out && !was_stale && m_q.size() < DEPTH) begin
          m_ce     = 1;
          m_ce_pc  = m_pc;
          m_req_pc = m_pc;
          m_pc     = m_pc + 32'd4;
          m_out    = 1;
        end else begin
          m_ce = 0;
        end
      end
      if (mem_resp) mem_pend = 0;
      else if (mem_pend && mem_cnt > 0) mem_cnt--;
      if (pre_ce) begin
        mem_pend = 1;
        mem_cnt  = $urandom_range(lat_hi, lat_lo) - 1;
        mem_pc   = pre_pc;
      end
    end
    w_pend = w_pre_ce;
    if (w_pre_ce) begin
      w_req_pc = w_pre_pc;
      if (w_pcs.size() < 3) w_pcs.push_back(w_pre_pc);
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_ce"}, {31'b0, out_mem_ce}, 32'h0);
    check({tag, "_mem_pc"}, out_mem_pc, 32'h0);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'h0);
    check({tag, "_instr"}, out_instr, 32'h0);
    check({tag, "_pc"}, out_pc, 32'h0);
    check({tag, "_count"}, {29'b0, out_iq_count}, 32'h0);
    check({tag, "_store"}, {31'b0, out_store_ce}, 32'h0);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc = 32'h0; m_out = 0; m_stale = 0; m_ce = 0;
    mem_pend = 0; mem_cnt = 0; w_pend = 0;
  endtask

  task automatic wait_issue(input string tag);
    for (int i = 0; i < 30 && !m_ce; i++) step(0, 32'h0, 0);
    check(tag, {31'b0, m_ce}, 32'h1);
  endtask

  int n;

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("rst");
    model_reset();
    #1 rst = 1'b1;

    // back-to-back fetch, latency 1, consumers idle
    issue_pc.delete(); issue_cyc.delete(); disp_pc.delete();
    lat_lo = 1; lat_hi = 1;
    repeat (12) step(0, 32'h0, 0);
    check("a_nissue", (issue_pc.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
    if (issue_pc.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("a_issue_pc", issue_pc[i], 32'(i * 4));
      check("a_gap", 32'(issue_cyc[3] - issue_cyc[2]), 32'd2);
    end
    check("a_ndisp", (disp_pc.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
    if (disp_pc.size() >= 3)
      for (int i = 0; i < 3; i++) check("a_disp_pc", disp_pc[i], 32'(i * 4));
    check("w_n", w_pcs.size(), 32'd3);
    if (w_pcs.size() == 3) begin
      check("w_pc0", w_pcs[0], 32'hFFFF_FFF8);
      check("w_pc1", w_pcs[1], 32'hFFFF_FFFC);
      check("w_pc2", w_pcs[2], 32'h0000_0000);
    end

    // consumers stalled: queue saturates, no further requests
    in_rs_idle = 1'b0;
    repeat (20) step(0, 32'h0, 0);
    check("b_sat", {29'b0, out_iq_count}, 32'd4);
    n = issue_pc.size();
    repeat (8) step(0, 32'h0, 0);
    check("b_no5th", issue_pc.size() - n, 32'd0);

    // release: drains in order, fetching resumes
    in_rs_idle = 1'b1;
    disp_pc.delete();
    repeat (14) step(0, 32'h0, 0);
    check("c_ndisp", (disp_pc.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
    if (disp_pc.size() >= 5)
      for (int i = 1; i < 5; i++) check("c_order", disp_pc[i], disp_pc[0] + 32'(i * 4));

    // redirect while a request is outstanding with its response still pending
    lat_lo = 3; lat_hi = 3;
    wait_issue("d_wait");
    step(0, 32'h0, 0);
    issue_pc.delete(); disp_pc.delete();
    step(1, 32'h100, 0);
    check("d_flush", {29'b0, out_iq_count}, 32'd0);
    repeat (16) step(0, 32'h0, 0);
    check("d_nissue", (issue_pc.size() >= 1 && disp_pc.size() >= 1) ? 32'd1 : 32'd0, 32'd1);
    if (issue_pc.size() >= 1) check("d_issue_pc", issue_pc[0], 32'h100);
    if (disp_pc.size() >= 1) check("d_disp_pc", disp_pc[0], 32'h100);

    // redirect in the same cycle as the response
    lat_lo = 1; lat_hi = 1;
    wait_issue("e_wait");
    step(0, 32'h0, 0);
    issue_pc.delete();
    check("e_resp_due", {31'b0, mem_pend && mem_cnt == 0}, 32'h1);
    step(1, 32'h200, 0);
    repeat (4) step(0, 32'h0, 0);
    check("e_nissue", (issue_pc.size() >= 1) ? 32'd1 : 32'd0, 32'd1);
    if (issue_pc.size() >= 1) check("e_issue_pc", issue_pc[0], 32'h200);

    // randomized traffic: stalls, rdy gaps, redirects, variable latency
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 600; i++) begin
      in_rs_idle  = ($urandom_range(3, 0) != 0);
      in_lsb_idle = ($urandom_range(4, 0) != 0);
      in_rob_idle = ($urandom_range(5, 0) != 0);
      rdy         = ($urandom_range(7, 0) != 0);
      if ($urandom_range(19, 0) == 0)
        step(1, ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC), 0);
      else
        step(0, 32'h0, 0);
    end

    // rdy low mid-WAIT, then asynchronous reset while waiting
    rdy = 1'b1; in_rs_idle = 1'b1; in_lsb_idle = 1'b1; in_rob_idle = 1'b1;
    lat_lo = 3; lat_hi = 3;
    wait_issue("f_wait");
    step(0, 32'h0, 0);
    rdy = 1'b0;
    repeat (3) step(0, 32'h0, 0);
    check("f_hold_cnt", {29'b0, out_iq_count}, m_q.size());
    check("f_hold_out", {31'b0, m_out}, 32'h1);
    rdy = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("arst");
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    issue_pc.delete();
    step(0, 32'h0, 1);
    repeat (8) step(0, 32'h0, 0);
    check("f_nissue", (issue_pc.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
    if (issue_pc.size() >= 2) begin
      check("f_first_pc", issue_pc[0], 32'h0);
      check("f_second_pc", issue_pc[1], 32'h4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
